// File: rtl/aes_byte_seq_ctrl_pkg.sv
// Shared types and constants for the byte-serial AES sequencer.
package aes_ctrl_pkg;

   // Default geometry of the AES-128 byte-serial core
   localparam int AES_NR_DEF = 10;
   localparam int AES_NB_DEF = 16;
   localparam int AES_NC_DEF = 4;

   // Width of the byte and round counters and of the index outputs
   localparam int CNT_W = 4;
   localparam int SE_W  = 5;

   // Bit positions inside the state-array enable vector
   localparam int SE_BYTE   = 0;
   localparam int SE_MIX    = 1;
   localparam int SE_UNLOAD = 2;
   localparam int SE_HOLD   = 3;
   localparam int SE_ROT    = 4;

   // State encodings kept as plain constants so legacy code can match on them
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_KEYSB = 3'd2;
   localparam logic [2:0] ST_ROUND = 3'd3;
   localparam logic [2:0] ST_MIX   = 3'd4;
   localparam logic [2:0] ST_OUT   = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      KEYSB = ST_KEYSB,
      ROUND = ST_ROUND,
      MIX   = ST_MIX,
      OUT   = ST_OUT
   } ctrl_state_e;

   // Last byte index of the phase the sequencer is currently in
   function automatic logic [CNT_W-1:0] phase_last(input ctrl_state_e st, input int nb, input int nc);
      logic [CNT_W-1:0] last;
      case (st)
         LOAD, ROUND:     last = CNT_W'(nb - 1);
         KEYSB, MIX, OUT: last = CNT_W'(nc - 1);
         default:         last = {CNT_W{1'b0}};
      endcase
      return last;
   endfunction

endpackage

// File: rtl/aes_byte_seq_ctrl_if.sv
// Command/control bundle between the system side, the sequencer and the AES core.
interface aes_byte_seq_ctrl_if;
   import aes_ctrl_pkg::*;

   logic             start;
   logic             enc_dec_req;
   logic             key_ready;
   logic             busy;
   logic             done;
   logic             data_req;
   logic             out_valid;
   logic [CNT_W-1:0] round_idx;
   logic [CNT_W-1:0] byte_idx;
   logic [SE_W-1:0]  se;
   logic             in_round_sel;
   logic             sb_sel;
   logic             last_rnd_sel;
   logic             enc_dec;
   logic             key_stored;

   // Sequencer side: takes requests, drives the core controls
   modport master (
      input  start, enc_dec_req, key_ready,
      output busy, done, data_req, out_valid, round_idx, byte_idx, se,
             in_round_sel, sb_sel, last_rnd_sel, enc_dec, key_stored
   );

   // Requester / core side
   modport slave (
      output start, enc_dec_req, key_ready,
      input  busy, done, data_req, out_valid, round_idx, byte_idx, se,
             in_round_sel, sb_sel, last_rnd_sel, enc_dec, key_stored
   );

endinterface

// File: rtl/aes_byte_seq_ctrl_phase_cnt.sv
// Loadable up-counter with terminal-count flag; saturates at MAX_LEN-1.
module aes_phase_cnt
   import aes_ctrl_pkg::*;
#(
   parameter int MAX_LEN = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] last_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN - 1);

   logic [CNT_W-1:0] cnt_q;

   // Count register: load wins over increment, never runs past CNT_MAX
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (inc_i && (cnt_q < CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/aes_byte_seq_ctrl.sv
// Cycle-level phase sequencer for the byte-serial AES-128 core.
// Outputs are pure decodes of registered state/counters (plus a registered done).
module aes_byte_seq_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int NR = AES_NR_DEF,
   parameter int NB = AES_NB_DEF,
   parameter int NC = AES_NC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   aes_byte_seq_ctrl_if.master bus
);

   localparam logic [CNT_W-1:0] NR_L = CNT_W'(NR);

   ctrl_state_e      state_q, state_d;
   logic             enc_dec_q, enc_dec_d;
   logic             done_q, done_d;

   logic [CNT_W-1:0] byte_cnt, byte_last, rnd_cnt, rnd_val;
   logic             byte_tc, byte_clr, byte_inc;
   logic             rnd_tc, rnd_load, rnd_inc;

   assign byte_last = phase_last(state_q, NB, NC);

   aes_phase_cnt #(.MAX_LEN(NB)) u_byte_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (byte_clr),
      .load_val_i ({CNT_W{1'b0}}),
      .inc_i      (byte_inc),
      .last_i     (byte_last),
      .cnt_o      (byte_cnt),
      .tc_o       (byte_tc)
   );

   aes_phase_cnt #(.MAX_LEN(NR + 1)) u_rnd_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (rnd_load),
      .load_val_i (rnd_val),
      .inc_i      (rnd_inc),
      .last_i     (NR_L),
      .cnt_o      (rnd_cnt),
      .tc_o       (rnd_tc)
   );

   // Next-state and counter control; every phase exits on its last byte
   always_comb begin
      state_d   = state_q;
      enc_dec_d = enc_dec_q;
      done_d    = 1'b0;
      byte_clr  = 1'b0;
      byte_inc  = 1'b0;
      rnd_load  = 1'b0;
      rnd_val   = {CNT_W{1'b0}};
      rnd_inc   = 1'b0;
      case (state_q)
         IDLE: begin
            byte_clr = 1'b1;
            if (bus.start && bus.key_ready) begin
               state_d   = LOAD;
               enc_dec_d = bus.enc_dec_req;
               rnd_load  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (byte_tc) begin
               state_d  = KEYSB;
               byte_clr = 1'b1;
               rnd_load = 1'b1;
               rnd_val  = CNT_W'(1);
            end else begin
               byte_inc = 1'b1;
            end
         end
         KEYSB: begin
            if (byte_tc) begin
               state_d  = ROUND;
               byte_clr = 1'b1;
            end else begin
               byte_inc = 1'b1;
            end
         end
         ROUND: begin
            if (byte_tc) begin
               byte_clr = 1'b1;
               // The final round has no column mix in either direction
               if (rnd_tc) begin
                  state_d  = OUT;
                  rnd_load = 1'b1;
               end else begin
                  state_d = MIX;
               end
            end else begin
               byte_inc = 1'b1;
            end
         end
         MIX: begin
            if (byte_tc) begin
               state_d  = KEYSB;
               byte_clr = 1'b1;
               rnd_inc  = 1'b1;
            end else begin
               byte_inc = 1'b1;
            end
         end
         OUT: begin
            if (byte_tc) begin
               state_d  = IDLE;
               byte_clr = 1'b1;
               done_d   = 1'b1;
            end else begin
               byte_inc = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            byte_clr = 1'b1;
            rnd_load = 1'b1;
         end
      endcase
   end

   // State, direction latch and done pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         enc_dec_q <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         enc_dec_q <= enc_dec_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy         = (state_q != IDLE);
   assign bus.done         = done_q;
   assign bus.data_req     = (state_q == LOAD);
   assign bus.out_valid    = (state_q == OUT);
   assign bus.round_idx    = rnd_cnt;
   assign bus.byte_idx     = byte_cnt;
   assign bus.in_round_sel = (state_q != LOAD);
   assign bus.sb_sel       = (state_q == KEYSB);
   assign bus.last_rnd_sel = (state_q == ROUND) && rnd_tc;
   assign bus.enc_dec      = enc_dec_q;
   assign bus.key_stored   = (state_q != KEYSB);

   assign bus.se[SE_BYTE]   = (state_q == LOAD) || (state_q == ROUND);
   assign bus.se[SE_MIX]    = (state_q == MIX);
   assign bus.se[SE_UNLOAD] = (state_q == OUT);
   assign bus.se[SE_HOLD]   = (state_q == KEYSB);
   assign bus.se[SE_ROT]    = (state_q == ROUND) && (byte_cnt == CNT_W'(NB - 1));

endmodule

// File: tb/tb_aes_byte_seq_ctrl.sv
// Self-checking bench: default (NR=10) and NR=2 sequencers against a schedule model.
module tb_aes_byte_seq_ctrl;
   import aes_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, key_ready, enc_dec_req;

   aes_byte_seq_ctrl_if if0 ();
   aes_byte_seq_ctrl_if if1 ();

   assign if0.start = start;  assign if0.key_ready = key_ready;  assign if0.enc_dec_req = enc_dec_req;
   assign if1.start = start;  assign if1.key_ready = key_ready;  assign if1.enc_dec_req = enc_dec_req;

   aes_byte_seq_ctrl dut0 (.clk(clk), .rst(rst), .bus(if0));
   aes_byte_seq_ctrl #(.NR(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   typedef struct packed {
      logic       busy;
      logic       data_req;
      logic       out_valid;
      logic [3:0] round_idx;
      logic [3:0] byte_idx;
      logic [4:0] se;
      logic       in_round_sel;
      logic       sb_sel;
      logic       last_rnd_sel;
      logic       key_stored;
   } obs_t;

   obs_t act [2];
   logic act_done [2];
   logic act_enc [2];
   assign act[0] = {if0.busy, if0.data_req, if0.out_valid, if0.round_idx, if0.byte_idx, if0.se,
                    if0.in_round_sel, if0.sb_sel, if0.last_rnd_sel, if0.key_stored};
   assign act[1] = {if1.busy, if1.data_req, if1.out_valid, if1.round_idx, if1.byte_idx, if1.se,
                    if1.in_round_sel, if1.sb_sel, if1.last_rnd_sel, if1.key_stored};
   assign act_done[0] = if0.done;  assign act_done[1] = if1.done;
   assign act_enc[0]  = if0.enc_dec;  assign act_enc[1] = if1.enc_dec;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
      end
   endtask

   // ---------------- schedule model ----------------
   function automatic int nr_of(input int k);
      return (k == 0) ? 10 : 2;
   endfunction

   function automatic int busy_len(input int nr);
      return 16 + nr * (4 + 16) + (nr - 1) * 4 + 4;
   endfunction

   function automatic obs_t idle_obs();
      obs_t e;
      e = '0;
      e.in_round_sel = 1'b1;
      e.key_stored   = 1'b1;
      return e;
   endfunction

   // Expected outputs on busy cycle t (1-based) of an operation with nr rounds
   function automatic obs_t exp_at(input int nr, input int t);
      obs_t e;
      int p;
      e = idle_obs();
      e.busy = 1'b1;
      p = t - 1;
      if (p < 16) begin
         e.data_req = 1'b1; e.in_round_sel = 1'b0; e.byte_idx = 4'(p); e.se[0] = 1'b1;
         return e;
      end
      p -= 16;
      for (int r = 1; r <= nr; r++) begin
         if (p < 4) begin
            e.round_idx = 4'(r); e.byte_idx = 4'(p); e.se[3] = 1'b1; e.sb_sel = 1'b1; e.key_stored = 1'b0;
            return e;
         end
         p -= 4;
         if (p < 16) begin
            e.round_idx = 4'(r); e.byte_idx = 4'(p); e.se[0] = 1'b1; e.se[4] = (p == 15);
            e.last_rnd_sel = (r == nr);
            return e;
         end
         p -= 16;
         if (r < nr) begin
            if (p < 4) begin
               e.round_idx = 4'(r); e.byte_idx = 4'(p); e.se[1] = 1'b1;
               return e;
            end
            p -= 4;
         end
      end
      e.out_valid = 1'b1; e.byte_idx = 4'(p); e.se[2] = 1'b1;
      return e;
   endfunction

   int   m_t [2];
   logic m_done [2];
   logic m_enc [2];
   logic chk_en = 1'b0;

   // Model: position inside the current operation, done and direction latch
   always @(posedge clk) begin
      if (rst) chk_en <= 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_t[k] <= 0; m_done[k] <= 1'b0; m_enc[k] <= 1'b1;
         end else if (m_t[k] == 0) begin
            m_done[k] <= 1'b0;
            if (start && key_ready) begin
               m_t[k] <= 1; m_enc[k] <= enc_dec_req;
            end
         end else if (m_t[k] == busy_len(nr_of(k))) begin
            m_t[k] <= 0; m_done[k] <= 1'b1;
         end else begin
            m_t[k] <= m_t[k] + 1; m_done[k] <= 1'b0;
         end
      end
   end

   obs_t e_cmp;
   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            e_cmp = (m_t[k] == 0) ? idle_obs() : exp_at(nr_of(k), m_t[k]);
            check($sformatf("outs%0d", k), 32'(act[k]), 32'(e_cmp));
            check($sformatf("done%0d", k), 32'(act_done[k]), 32'(m_done[k]));
            check($sformatf("enc_dec%0d", k), 32'(act_enc[k]), 32'(m_enc[k]));
         end
      end
   end

   // ---------------- directed operations ----------------
   int s_busy, s_dreq, s_dreq_first, s_dreq_last, s_done, s_sb, s_ov, s_lrs, s_mix, s_ks0, s_enc1, s_busy2;
   int rseq[$];

   task automatic run_op(input logic enc, input int pulse_at, input int kr_drop_at, input int rst_at);
      s_busy = 0; s_dreq = 0; s_dreq_first = 0; s_dreq_last = 0; s_done = 0; s_sb = 0;
      s_ov = 0; s_lrs = 0; s_mix = 0; s_ks0 = 0; s_enc1 = 0; s_busy2 = 0;
      rseq.delete();
      @(negedge clk);
      start = 1'b1; enc_dec_req = enc; key_ready = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 30) enc_dec_req = ~enc;
         if (pulse_at != 0 && c == pulse_at) start = 1'b1;
         if (pulse_at != 0 && c == pulse_at + 1) start = 1'b0;
         if (kr_drop_at != 0 && c == kr_drop_at) key_ready = 1'b0;
         if (rst_at != 0 && c == rst_at) begin
            check("round_at_rst", 32'(if0.round_idx), 32'd5);
            check("byte_at_rst", 32'(if0.byte_idx), 32'd3);
            rst = 1'b1;
         end
         if (rst_at != 0 && c == rst_at + 1) begin
            check("busy_after_rst", 32'(if0.busy), 32'd0);
            check("se_after_rst", 32'(if0.se), 32'd0);
            check("enc_after_rst", 32'(if0.enc_dec), 32'd1);
            rst = 1'b0;
         end
         if (if0.busy) s_busy++;
         if (if0.data_req) begin
            s_dreq++;
            if (s_dreq_first == 0) s_dreq_first = c;
            s_dreq_last = c;
         end
         if (if0.sb_sel) s_sb++;
         if (if0.out_valid) s_ov++;
         if (if0.last_rnd_sel) s_lrs++;
         if (if0.se[1]) s_mix++;
         if (!if0.key_stored) s_ks0++;
         if (if0.busy && if0.enc_dec) s_enc1++;
         if (if1.busy) begin
            s_busy2++;
            if (rseq.size() == 0 || rseq[$] != int'(if1.round_idx)) rseq.push_back(int'(if1.round_idx));
         end
         if (if0.done) begin
            s_done = c;
            break;
         end
      end
      start = 1'b0; key_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; key_ready = 1'b0; enc_dec_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(if0.busy), 32'd0);
      check("rst_in_round_sel", 32'(if0.in_round_sel), 32'd1);
      check("rst_enc_dec", 32'(if0.enc_dec), 32'd1);
      check("rst_key_stored", 32'(if0.key_stored), 32'd1);
      check("rst_se", 32'(if0.se), 32'd0);
      rst = 1'b0;
      key_ready = 1'b1;

      // Encrypt, default geometry (and NR=2 instance in parallel)
      run_op(1'b1, 0, 0, 0);
      check("enc_busy_len", 32'(s_busy), 32'd256);
      check("enc_dreq_cnt", 32'(s_dreq), 32'd16);
      check("enc_dreq_first", 32'(s_dreq_first), 32'd1);
      check("enc_dreq_last", 32'(s_dreq_last), 32'd16);
      check("enc_done_cycle", 32'(s_done), 32'd257);
      check("enc_sb_sel_cnt", 32'(s_sb), 32'd40);
      check("enc_out_valid_cnt", 32'(s_ov), 32'd4);
      check("enc_last_rnd_cnt", 32'(s_lrs), 32'd16);
      check("enc_mix_cnt", 32'(s_mix), 32'd36);
      check("nr2_busy_len", 32'(s_busy2), 32'd64);
      check("nr2_round_seq_len", 32'(rseq.size()), 32'd4);
      if (rseq.size() == 4)
         check("nr2_round_seq", 32'((rseq[0] << 12) | (rseq[1] << 8) | (rseq[2] << 4) | rseq[3]), 32'h0120);

      // Decrypt
      run_op(1'b0, 0, 0, 0);
      check("dec_busy_len", 32'(s_busy), 32'd256);
      check("dec_done_cycle", 32'(s_done), 32'd257);
      check("dec_key_stored0_cnt", 32'(s_ks0), 32'd40);
      check("dec_enc_dec_high", 32'(s_enc1), 32'd0);

      // Start while busy and key_ready drop mid-operation are ignored
      run_op(1'b1, 100, 50, 0);
      check("ign_busy_len", 32'(s_busy), 32'd256);
      check("ign_done_cycle", 32'(s_done), 32'd257);
      check("ign_nr2_busy_len", 32'(s_busy2), 32'd64);

      // Start with key_ready low stays idle
      key_ready = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("nokey_busy0", 32'(if0.busy), 32'd0);
         check("nokey_busy1", 32'(if1.busy), 32'd0);
      end
      start = 1'b0;
      key_ready = 1'b1;

      // Reset in round 5, then a fresh full operation
      run_op(1'b1, 0, 0, 120);
      check("rst_no_done", 32'(s_done), 32'd0);
      check("rst_busy_len", 32'(s_busy), 32'd120);
      run_op(1'b0, 0, 0, 0);
      check("after_rst_busy_len", 32'(s_busy), 32'd256);
      check("after_rst_done_cycle", 32'(s_done), 32'd257);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_byte_seq_ctrl.md
Name: aes_byte_seq_ctrl

Overview:
- Cycle-level sequencer for the byte-serial AES-128 encrypt/decrypt core (state array, shared S-box, add-round-key, mix/inv-mix column).
- Accepts a start request and walks the core through the phases below, driving the core's control inputs every cycle:
  - initial key add;
  - per-round key S-box slots, byte rounds and column mixes;
  - final unload.
- Sits between the system-level command interface and the core; also exposes byte/round indices to the key schedule.

Parameters:
- NR, 10, number of AES rounds (10 for AES-128; legal range 2..14).
- NB, 16, state bytes per round (byte-phase length).
- NC, 4, columns (length of key-S-box, mix and unload phases).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- enc_dec_req  in  1  1 = encrypt, 0 = decrypt; latched on start accept.
- key_ready  in  1  key schedule holds a valid round-0 key; start is ignored while low.
- busy  out  1  high from the cycle after accept through the last OUT cycle.
- done  out  1  one-cycle pulse on the first IDLE cycle after OUT.
- data_req  out  1  high during LOAD; upstream must present one plaintext/ciphertext byte per cycle.
- out_valid  out  1  high during OUT; data_out word valid each cycle.
- round_idx  out  4  0 in LOAD, r (1..NR) in round-r phases, 0 otherwise.
- byte_idx  out  4  position within current phase (0..NB-1 or 0..NC-1), 0 in IDLE.
- se  out  5  state-array enables:
  - [0] byte shift (LOAD, ROUND);
  - [1] mixed-column capture (MIX);
  - [2] unload shift (OUT);
  - [3] hold, KEYSB;
  - [4] row-rotate, asserted only on byte_idx 15 of ROUND.
- in_round_sel  out  1  0 in LOAD (external data path), 1 otherwise.
- sb_sel  out  1  1 in KEYSB (S-box serves key schedule), 0 otherwise.
- last_rnd_sel  out  1  1 during ROUND of round NR only.
- enc_dec  out  1  latched enc_dec_req, held stable while busy.
- key_stored  out  1  0 in KEYSB (forces forward S-box for key expansion), 1 otherwise.

Behaviour:
- Reset values:
  - FSM in IDLE; all counters 0.
  - Every output 0, except in_round_sel=1, enc_dec=1 and key_stored=1.
- Reset is synchronous and active-high.
- States and transitions:
  - IDLE -> LOAD when start & key_ready.
  - LOAD, NB cycles -> KEYSB with round_idx=1.
  - KEYSB, NC cycles -> ROUND.
  - ROUND, NB cycles -> MIX if round_idx<NR, else OUT.
  - MIX, NC cycles -> KEYSB with round_idx+1.
  - OUT, NC cycles -> IDLE, with done pulsed on that IDLE cycle.
- Phase exits happen on byte_idx == phase_len-1; byte_idx wraps to 0 on every transition.
- MIX is skipped in round NR for both encrypt and decrypt, so the schedule is identical in both modes.
- Total busy length: NB + NR*(NC+NB) + (NR-1)*NC + NC. This is 256 cycles for the defaults; done follows 257 cycles after the accept edge.
- All outputs are registered-state decodes (Moore); no output depends combinationally on start.
- Conflicting requests:
  - start while busy: ignored, with no queuing.
  - start with key_ready low: ignored, and the FSM stays in IDLE.
  - start held high across done: a new operation is accepted on the done cycle itself, because that cycle is IDLE.
- key_ready falling mid-operation: no effect; it is checked only at accept.
- enc_dec_req changes while busy: no effect.
- rst mid-operation: returns to IDLE and reset outputs next cycle; done is not pulsed.
- round_idx never exceeds NR; byte_idx never exceeds NB-1.

Decomposition:
- Package aes_ctrl_pkg contains:
  - typedef enum ctrl_state_e {IDLE, LOAD, KEYSB, ROUND, MIX, OUT};
  - localparam phase lengths;
  - SE_* bit-index constants for the five se bits.
- Sub-module aes_phase_cnt: loadable phase counter with terminal-count flag, parameterised by max length. It is shared by the byte and round counters.

Test Plan:
- Encrypt, defaults: rst 2 cycles, key_ready=1, pulse start with enc_dec_req=1 -> required response:
  - busy high 256 cycles;
  - data_req high cycles 1..16;
  - done pulses at cycle 257;
  - sb_sel high for exactly 40 cycles;
  - out_valid high 4 cycles.
- Round-10 check -> last_rnd_sel high only for the 16 ROUND cycles with round_idx=10; se[1] never high in round 10 (exactly 36 MIX cycles in total).
- Decrypt, enc_dec_req=0 -> same 256-cycle timing; enc_dec=0 throughout; key_stored=0 exactly in the 40 KEYSB cycles.
- start pulsed at cycle 100 of an operation, and start with key_ready=0 in IDLE -> both ignored; busy and indices are unchanged.
- rst asserted at cycle 120 (round 5 ROUND) -> next cycle is IDLE, all outputs at reset values, no done; a fresh start then runs the full 256 cycles.
- NR=2 instance -> busy length 16+2*20+4+4 = 64 cycles; round_idx sequence 0,1,2,0.
